// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one UART transmitter byte stream among NUM_REQ requesters.
// The granted stream is passed through combinationally; a grant ends on last byte, burst limit or idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 7200
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic                       tx_active,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       timeout_pulse,
  output logic                       busy
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] IDLE_END  = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   grant_idx_next, last_grant, last_grant_next, pick;
  logic               grant_valid_next, timeout_next, any_valid;
  logic [CNT_W-1:0]   burst_cnt, burst_next, idle_cnt, idle_next;
  logic [31:0]        cand;
  logic [7:0]         req_bytes [NUM_REQ];
  logic               g_valid, g_last, transfer, rel;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) req_bytes[i] = req_data[8*i +: 8];
  end

  // Round-robin search starting just after the previous grant holder.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant) + i) % NUM_REQ;
      if (!any_valid && req_valid[IDX_W'(cand)]) begin
        any_valid = 1'b1;
        pick      = IDX_W'(cand);
      end
    end
  end

  // Zero-latency pass-through of the granted requester.
  always_comb begin
    g_valid   = req_valid[grant_idx];
    g_last    = req_last[grant_idx];
    tx_data   = req_bytes[grant_idx];
    tx_valid  = 1'b0;
    req_ready = '0;
    if (state == XFER) begin
      tx_valid             = g_valid;
      req_ready[grant_idx] = tx_ready;
    end
    transfer = tx_valid & tx_ready;
  end

  assign busy = grant_valid | tx_active;

  always_comb begin
    state_next       = state;
    grant_idx_next   = grant_idx;
    grant_valid_next = grant_valid;
    timeout_next     = 1'b0;
    last_grant_next  = last_grant;
    burst_next       = burst_cnt;
    idle_next        = idle_cnt;
    rel              = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next       = XFER;
          grant_idx_next   = pick;
          grant_valid_next = 1'b1;
          burst_next       = '0;
          idle_next        = '0;
        end
      end
      XFER: begin
        if (transfer) begin
          burst_next = burst_cnt + CNT_W'(1);
          idle_next  = '0;
          rel        = g_last || (burst_cnt == BURST_END);
        end else if (!g_valid) begin
          if (idle_cnt == IDLE_END) begin
            rel          = 1'b1;
            timeout_next = 1'b1;
          end else if (idle_cnt != '1) begin
            idle_next = idle_cnt + CNT_W'(1);
          end
        end else begin
          // Transmitter stall: requester is not idle.
          idle_next = '0;
        end
        if (rel) begin
          state_next       = IDLE;
          last_grant_next  = grant_idx;
          grant_valid_next = 1'b0;
          burst_next       = '0;
          idle_next        = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_idx     <= '0;
      grant_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      burst_cnt     <= '0;
      idle_cnt      <= '0;
    end else begin
      state         <= state_next;
      grant_idx     <= grant_idx_next;
      grant_valid   <= grant_valid_next;
      timeout_pulse <= timeout_next;
      last_grant    <= last_grant_next;
      burst_cnt     <= burst_next;
      idle_cnt      <= idle_next;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus stream sequences for
// single packet, burst limit, idle timeout, backpressure and mid-packet reset.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_active;
  logic        grant_valid, timeout_pulse, busy;
  logic [1:0]  grant_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_active(tx_active), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .timeout_pulse(timeout_pulse), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] v, l;
    logic       rdy, act;
    logic       e_gv;
    logic [1:0] e_gi;
    logic       e_txv;
    logic [7:0] e_txd;
    logic [3:0] e_rdy;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                              input logic act, input logic gv, input logic [1:0] gi,
                              input logic txv, input logic [7:0] txd, input logic [3:0] er,
                              input logic bz);
    vec_t r;
    r.v = v; r.l = l; r.rdy = rdy; r.act = act; r.e_gv = gv; r.e_gi = gi;
    r.e_txv = txv; r.e_txd = txd; r.e_rdy = er; r.e_busy = bz;
    return r;
  endfunction

  localparam int NV = 20;
  vec_t vecs [NV];

  // Stream engine state: per-requester byte lists {last,data}.
  logic [8:0] mem [4][16];
  int         len [4];
  int         pos [4];
  int         log_n;
  logic [1:0] log_idx [64];
  logic [1:0] log_gi  [64];
  logic [7:0] log_dat [64];
  int         log_cyc [64];
  logic       gv_log  [256];
  logic       tp_log  [256];
  int         stall_bad;

  task automatic clr();
    for (int i = 0; i < 4; i++) len[i] = 0;
  endtask

  function automatic int tp_count(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (tp_log[k] === 1'b1) c++;
    return c;
  endfunction

  // mode 0: ready always; 1: ready 1 cycle in 10; 2: ready low until cycle 51
  task automatic run_streams(input int ncyc, input int mode);
    log_n = 0;
    stall_bad = 0;
    for (int i = 0; i < 4; i++) pos[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i]       = (pos[i] < len[i]);
        req_data[8*i +: 8] = mem[i][pos[i]][7:0];
        req_last[i]        = mem[i][pos[i]][8] & req_valid[i];
      end
      case (mode)
        1:       tx_ready = (c % 10 == 9);
        2:       tx_ready = (c >= 51);
        default: tx_ready = 1'b1;
      endcase
      #1;
      gv_log[c] = grant_valid;
      tp_log[c] = timeout_pulse;
      if (mode == 2 && c >= 1 && c <= 50)
        if (tx_valid !== 1'b1 || tx_data !== mem[0][0][7:0]) stall_bad++;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i] === 1'b1) begin
          chk("xfer_valid", 32'(tx_valid), 32'd1);
          chk("xfer_data", 32'(tx_data), 32'(mem[i][pos[i]][7:0]));
          if (log_n < 64) begin
            log_idx[log_n] = 2'(i);
            log_gi[log_n]  = grant_idx;
            log_dat[log_n] = mem[i][pos[i]][7:0];
            log_cyc[log_n] = c;
            log_n++;
          end
          pos[i]++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) chk("drained", 32'(pos[i]), 32'(len[i]));
    req_valid = '0;
    req_last  = '0;
  endtask

  logic [1:0] exp_idx [11];
  logic [7:0] exp_dat [11];

  initial begin
    rst_n = 1'b0; req_data = '0; req_valid = '0; req_last = '0;
    tx_ready = 1'b0; tx_active = 1'b0;

    //              v     l     rdy act  gv gi txv txd    rdy_e  busy
    vecs[0]  = mk(4'h0, 4'h0, 1, 0,  0, 0, 0, 8'h00, 4'h0, 0);
    vecs[1]  = mk(4'h0, 4'h0, 1, 1,  0, 0, 0, 8'h00, 4'h0, 1);
    vecs[2]  = mk(4'hF, 4'hF, 1, 0,  0, 0, 0, 8'h00, 4'h0, 0);
    vecs[3]  = mk(4'hF, 4'hF, 1, 0,  1, 0, 1, 8'hA0, 4'h1, 1);
    vecs[4]  = mk(4'hF, 4'hF, 1, 0,  0, 0, 0, 8'h00, 4'h0, 0);
    vecs[5]  = mk(4'hF, 4'hF, 1, 0,  1, 1, 1, 8'hB1, 4'h2, 1);
    vecs[6]  = mk(4'hF, 4'hF, 1, 0,  0, 1, 0, 8'h00, 4'h0, 0);
    vecs[7]  = mk(4'hF, 4'hF, 1, 0,  1, 2, 1, 8'hC2, 4'h4, 1);
    vecs[8]  = mk(4'hF, 4'hF, 1, 0,  0, 2, 0, 8'h00, 4'h0, 0);
    vecs[9]  = mk(4'hF, 4'hF, 1, 0,  1, 3, 1, 8'hD3, 4'h8, 1);
    vecs[10] = mk(4'hF, 4'hF, 1, 0,  0, 3, 0, 8'h00, 4'h0, 0);
    vecs[11] = mk(4'hF, 4'hF, 1, 0,  1, 0, 1, 8'hA0, 4'h1, 1);
    vecs[12] = mk(4'hF, 4'hF, 1, 0,  0, 0, 0, 8'h00, 4'h0, 0);
    vecs[13] = mk(4'hF, 4'hF, 1, 0,  1, 1, 1, 8'hB1, 4'h2, 1);
    vecs[14] = mk(4'h0, 4'h0, 1, 0,  0, 1, 0, 8'h00, 4'h0, 0);
    vecs[15] = mk(4'h0, 4'h0, 1, 0,  0, 1, 0, 8'h00, 4'h0, 0);
    vecs[16] = mk(4'h2, 4'h2, 1, 0,  0, 1, 0, 8'h00, 4'h0, 0);
    vecs[17] = mk(4'h2, 4'h2, 0, 0,  1, 1, 1, 8'hB1, 4'h0, 1);
    vecs[18] = mk(4'h2, 4'h2, 1, 0,  1, 1, 1, 8'hB1, 4'h2, 1);
    vecs[19] = mk(4'h0, 4'h0, 1, 0,  0, 1, 0, 8'h00, 4'h0, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, round-robin order, re-win when alone, stalled byte.
    req_data = 32'hD3C2_B1A0;
    for (int k = 0; k < NV; k++) begin
      req_valid = vecs[k].v; req_last = vecs[k].l;
      tx_ready  = vecs[k].rdy; tx_active = vecs[k].act;
      #1;
      chk("tbl_grant_valid", 32'(grant_valid), 32'(vecs[k].e_gv));
      chk("tbl_grant_idx", 32'(grant_idx), 32'(vecs[k].e_gi));
      chk("tbl_tx_valid", 32'(tx_valid), 32'(vecs[k].e_txv));
      if (vecs[k].e_txv) chk("tbl_tx_data", 32'(tx_data), 32'(vecs[k].e_txd));
      chk("tbl_req_ready", 32'(req_ready), 32'(vecs[k].e_rdy));
      chk("tbl_busy", 32'(busy), 32'(vecs[k].e_busy));
      chk("tbl_timeout", 32'(timeout_pulse), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    tx_active = 1'b0;

    // Single packet from req 1 with sparse tx_ready.
    clr();
    len[1] = 3;
    mem[1][0] = {1'b0, 8'hA1}; mem[1][1] = {1'b0, 8'hA2}; mem[1][2] = {1'b1, 8'hA3};
    run_streams(60, 1);
    chk("single_count", 32'(log_n), 32'd3);
    chk("single_b0", 32'(log_dat[0]), 32'hA1);
    chk("single_b1", 32'(log_dat[1]), 32'hA2);
    chk("single_b2", 32'(log_dat[2]), 32'hA3);
    for (int k = 0; k < 3; k++) chk("single_gidx", 32'(log_gi[k]), 32'd1);
    chk("single_last_cyc", 32'(log_cyc[2]), 32'd29);
    chk("single_gv_at_last", 32'(gv_log[29]), 32'd1);
    chk("single_gv_after", 32'(gv_log[30]), 32'd0);
    chk("single_no_timeout", 32'(tp_count(60)), 32'd0);

    // Burst limit: req 2 streams 10 bytes while req 0 waits with one byte.
    clr();
    len[2] = 10;
    for (int k = 0; k < 10; k++) mem[2][k] = {(k == 9), 8'(8'h21 + k)};
    len[0] = 1;
    mem[0][0] = {1'b1, 8'h50};
    for (int k = 0; k < 11; k++) begin
      exp_idx[k] = (k == 4) ? 2'd0 : 2'd2;
      exp_dat[k] = (k < 4) ? 8'(8'h21 + k) : (k == 4) ? 8'h50 : 8'(8'h20 + k);
    end
    run_streams(40, 0);
    chk("burst_count", 32'(log_n), 32'd11);
    for (int k = 0; k < 11; k++) begin
      chk("burst_idx", 32'(log_idx[k]), 32'(exp_idx[k]));
      chk("burst_data", 32'(log_dat[k]), 32'(exp_dat[k]));
    end

    // Idle timeout: req 3 sends one byte without last, then goes quiet.
    clr();
    len[3] = 1; mem[3][0] = {1'b0, 8'h3C};
    len[0] = 1; mem[0][0] = {1'b1, 8'h0F};
    run_streams(30, 0);
    chk("to_count", 32'(log_n), 32'd2);
    chk("to_first_idx", 32'(log_idx[0]), 32'd3);
    chk("to_first_cyc", 32'(log_cyc[0]), 32'd1);
    chk("to_pulses", 32'(tp_count(30)), 32'd1);
    chk("to_pulse_cyc", 32'(tp_log[10]), 32'd1);
    chk("to_gv_before", 32'(gv_log[9]), 32'd1);
    chk("to_gv_release", 32'(gv_log[10]), 32'd0);
    chk("to_next_idx", 32'(log_idx[1]), 32'd0);
    chk("to_next_cyc", 32'(log_cyc[1]), 32'd11);

    // Backpressure: tx_ready low for 50 granted cycles must not time out.
    clr();
    len[0] = 1; mem[0][0] = {1'b1, 8'h5A};
    run_streams(60, 2);
    chk("bp_count", 32'(log_n), 32'd1);
    chk("bp_xfer_cyc", 32'(log_cyc[0]), 32'd51);
    chk("bp_stable", 32'(stall_bad), 32'd0);
    chk("bp_no_timeout", 32'(tp_count(60)), 32'd0);
    chk("bp_gv_held", 32'(gv_log[50]), 32'd1);

    // Reset during req 1's packet; req 0 must win first afterwards.
    req_data = 32'h0000_8070; req_valid = 4'b0011; req_last = 4'b0000; tx_ready = 1'b1;
    #1;
    chk("rst_pre_gv", 32'(grant_valid), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("rst_xfer_gv", 32'(grant_valid), 32'd1);
    chk("rst_xfer_gi", 32'(grant_idx), 32'd1);
    chk("rst_xfer_data", 32'(tx_data), 32'h80);
    @(posedge clk); @(negedge clk);
    req_data[15:8] = 8'h81;
    #1;
    chk("rst_xfer_data2", 32'(tx_data), 32'h81);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_timeout", 32'(timeout_pulse), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("rst_regrant_gv", 32'(grant_valid), 32'd1);
    chk("rst_regrant_gi", 32'(grant_idx), 32'd0);
    chk("rst_regrant_data", 32'(tx_data), 32'h70);
    chk("rst_regrant_ready", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(posedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
